fetch_unit: RTL and testbench

// - N-wide in-order fetch front end; sits between the I-memory/I-cache port and the fetch (instruction) buffer.
// - Issues one group request at a time, holds the returned group and releases it as the buffer has room.
// - A fetch group never crosses a cache line.
// - Branch-stack redirects squash in-flight/held work and restart at the restore PC; stale responses are drained.

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit_group_calc.sv | 30 +++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch front end: instruction/address words, fetch packets, FSM states.
package fetch_unit_pkg;

  localparam int unsigned ADDR_BITS = 32;
  localparam int unsigned INST_BITS = 32;

  typedef logic [INST_BITS-1:0] INST;
  typedef logic [ADDR_BITS-1:0] ADDR;

  typedef struct packed {
    INST  inst;
    ADDR  pc;
    logic taken;
  } FETCH_PACKET;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    FLUSH   = 3'd4
  } fetch_state_e;

  function automatic int unsigned fetch_cnt_bits(int unsigned fetch_width);
    return $clog2(fetch_width + 1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// I-memory request/response, branch-stack redirect and fetch-buffer write signals of the fetch unit.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned ADDR_W      = ADDR_BITS
);
  localparam int unsigned CNT_W = fetch_cnt_bits(FETCH_WIDTH);

  logic                                  imem_req_valid;
  logic                                  imem_req_ready;
  logic [ADDR_W-1:0]                     imem_req_addr;
  logic                                  imem_rsp_valid;
  logic [FETCH_WIDTH*INST_BITS-1:0]      imem_rsp_inst;
  logic                                  redirect_valid;
  logic [ADDR_W-1:0]                     redirect_pc;
  logic [CNT_W-1:0]                      fb_spots;
  logic [CNT_W-1:0]                      fb_valid_cnt;
  FETCH_PACKET [FETCH_WIDTH-1:0]         fb_packets;

  modport master (
    output imem_req_valid, imem_req_addr, fb_valid_cnt, fb_packets,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_inst,
           redirect_valid, redirect_pc, fb_spots
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, fb_valid_cnt, fb_packets,
    output imem_req_ready, imem_rsp_valid, imem_rsp_inst,
           redirect_valid, redirect_pc, fb_spots
  );

endinterface

// File: rtl/fetch_unit_group_calc.sv
// Per-cycle delivery sizing: how many held lanes go out, their PCs and which hold lane feeds each slot.
module fetch_unit_group_calc
  import fetch_unit_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned ADDR_W      = ADDR_BITS,
  localparam int unsigned CNT_W      = fetch_cnt_bits(FETCH_WIDTH),
  localparam int unsigned SEL_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic [ADDR_W-1:0]                   pc,
  input  logic [CNT_W-1:0]                    offset,
  input  logic [CNT_W-1:0]                    avail,
  input  logic [CNT_W-1:0]                    fb_spots,
  output logic [CNT_W-1:0]                    cnt,
  output logic [FETCH_WIDTH-1:0][ADDR_W-1:0]  lane_pc,
  output logic [FETCH_WIDTH-1:0][SEL_W-1:0]   lane_sel
);

  logic [CNT_W-1:0] remaining;

  always_comb begin
    remaining = avail - offset;
    cnt       = (fb_spots < remaining) ? fb_spots : remaining;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      lane_pc[k]  = pc + ADDR_W'(k << 2);
      lane_sel[k] = SEL_W'(offset + CNT_W'(k));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// N-wide in-order fetch front end: one outstanding I-memory group request, hold-and-release to the
// fetch buffer, line-bounded groups, redirect squash with stale-response drain.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       FETCH_WIDTH = 4,
  parameter int unsigned       ADDR_W      = ADDR_BITS,
  parameter int unsigned       LINE_BYTES  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CNT_W      = fetch_cnt_bits(FETCH_WIDTH);
  localparam int unsigned SEL_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int unsigned LINE_WORDS = LINE_BYTES / 4;
  localparam int unsigned LINE_OFF_W = $clog2(LINE_BYTES);

  fetch_state_e                           state_q, state_d;
  logic [ADDR_W-1:0]                      pc_q, pc_d;
  logic [FETCH_WIDTH-1:0][INST_BITS-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]                       offset_q, offset_d;
  logic [CNT_W-1:0]                       avail_q, avail_d;
  logic [CNT_W-1:0]                       grp_cnt, deliver_cnt;
  logic [FETCH_WIDTH-1:0][ADDR_W-1:0]     lane_pc;
  logic [FETCH_WIDTH-1:0][SEL_W-1:0]      lane_sel;
  FETCH_PACKET [FETCH_WIDTH-1:0]          pkts;
  int unsigned                            words_left;

  fetch_unit_group_calc #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .ADDR_W      (ADDR_W)
  ) u_group_calc (
    .pc       (pc_q),
    .offset   (offset_q),
    .avail    (avail_q),
    .fb_spots (bus.fb_spots),
    .cnt      (grp_cnt),
    .lane_pc  (lane_pc),
    .lane_sel (lane_sel)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    offset_d    = offset_q;
    avail_d     = avail_q;
    deliver_cnt = '0;
    words_left  = LINE_WORDS - 32'(pc_q[LINE_OFF_W-1:2]);

    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (bus.imem_req_ready) state_d = WAIT;
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          hold_d   = bus.imem_rsp_inst;
          offset_d = '0;
          avail_d  = (words_left < FETCH_WIDTH) ? CNT_W'(words_left) : CNT_W'(FETCH_WIDTH);
          state_d  = DELIVER;
        end
      end
      DELIVER: begin
        deliver_cnt = grp_cnt;
        pc_d        = pc_q + ADDR_W'({deliver_cnt, 2'b00});
        offset_d    = offset_q + deliver_cnt;
        if (offset_d == avail_q) state_d = REQ;
      end
      FLUSH: if (bus.imem_rsp_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above. A response landing in the same cycle
    // (WAIT or FLUSH) retires the outstanding request, so no drain is needed.
    if (bus.redirect_valid) begin
      pc_d        = bus.redirect_pc & ~ADDR_W'(3);
      hold_d      = '0;
      offset_d    = '0;
      avail_d     = '0;
      deliver_cnt = '0;
      case (state_q)
        REQ:         state_d = bus.imem_req_ready ? FLUSH : REQ;
        WAIT, FLUSH: state_d = bus.imem_rsp_valid ? REQ : FLUSH;
        default:     state_d = REQ;
      endcase
    end
  end

  always_comb begin
    pkts = '0;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      if (CNT_W'(k) < deliver_cnt) begin
        pkts[k].inst  = hold_q[lane_sel[k]];
        pkts[k].pc    = ADDR'(lane_pc[k]);
        pkts[k].taken = 1'b0;
      end
    end
  end

  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.fb_valid_cnt   = deliver_cnt;
  assign bus.fb_packets     = pkts;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      hold_q   <= '0;
      offset_q <= '0;
      avail_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      offset_q <= offset_d;
      avail_q  <= avail_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random traffic checked
// every cycle against a queue-based model of outstanding requests and undelivered instructions.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned FW = 4;
  localparam int unsigned LB = 32;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fetch_unit_if #(.FETCH_WIDTH(FW), .ADDR_W(32)) bus ();

  fetch_unit #(
    .FETCH_WIDTH (FW),
    .ADDR_W      (32),
    .LINE_BYTES  (LB),
    .RESET_PC    (32'h0)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Model: a request is either in flight (possibly stale) or not; returned words queue until written.
  bit          m_started;
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_pc;
  ent_t        m_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic        s_reqv;
  logic [31:0] s_addr;
  logic [2:0]  s_cnt;
  logic [31:0] s_pc[FW];
  logic [31:0] s_inst[FW];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_out     = 1'b0;
    m_stale   = 1'b0;
    m_pc      = 32'h0;
    m_q.delete();
  endtask

  task automatic cycle_now(input bit ready, input bit rsp, input logic [FW*32-1:0] inst,
                           input bit redir, input logic [31:0] rpc, input logic [2:0] spots);
    bit          exp_reqv;
    int unsigned exp_cnt;
    int unsigned n;
    ent_t        e;
    bus.imem_req_ready = ready;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_inst  = inst;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.fb_spots       = spots;
    #1;
    assert (!rsp || m_out) else $error("bench drove a response with nothing outstanding");
    exp_reqv = m_started && !m_out && (m_q.size() == 0);
    exp_cnt  = 0;
    if (!redir && !m_out) exp_cnt = (m_q.size() < spots) ? m_q.size() : 32'(spots);

    s_reqv = bus.imem_req_valid;
    s_addr = bus.imem_req_addr;
    s_cnt  = bus.fb_valid_cnt;
    for (int k = 0; k < FW; k++) begin
      s_pc[k]   = bus.fb_packets[k].pc;
      s_inst[k] = bus.fb_packets[k].inst;
    end

    chk("req_valid", 64'(s_reqv), 64'(exp_reqv));
    if (exp_reqv) chk("req_addr", 64'(s_addr), 64'(m_pc));
    chk("fb_valid_cnt", 64'(s_cnt), 64'(exp_cnt));
    for (int k = 0; k < FW; k++) begin
      if (k < int'(exp_cnt)) begin
        chk("pkt_inst", 64'(s_inst[k]), 64'(m_q[k].inst));
        chk("pkt_pc_taken", {31'b0, bus.fb_packets[k].taken, s_pc[k]}, {32'b0, m_q[k].pc});
      end
    end

    m_started = 1'b1;
    if (redir) begin
      m_pc = rpc & ~32'h3;
      m_q.delete();
      if (exp_reqv && ready) begin
        m_out   = 1'b1;
        m_stale = 1'b1;
      end else if (m_out && rsp) begin
        m_out = 1'b0;
      end else if (m_out) begin
        m_stale = 1'b1;
      end
    end else if (exp_reqv && ready) begin
      m_out   = 1'b1;
      m_stale = 1'b0;
    end else if (m_out && rsp) begin
      m_out = 1'b0;
      if (!m_stale) begin
        n = (LB - (m_pc % LB)) / 4;
        if (n > FW) n = FW;
        for (int unsigned i = 0; i < n; i++) begin
          e.inst = inst[32*i +: 32];
          e.pc   = m_pc + 32'(4 * i);
          m_q.push_back(e);
        end
        m_pc = m_pc + 32'(4 * n);
      end
    end else begin
      repeat (exp_cnt) void'(m_q.pop_front());
    end
  endtask

  task automatic step(input bit ready, input bit rsp, input logic [FW*32-1:0] inst,
                      input bit redir, input logic [31:0] rpc, input logic [2:0] spots);
    @(negedge clock);
    cycle_now(ready, rsp, inst, redir, rpc, spots);
  endtask

  logic [FW*32-1:0] g;
  logic [FW*32-1:0] rinst;
  logic [31:0]      rpc;

  initial begin
    model_reset();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_inst  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.fb_spots       = 3'd4;
    repeat (3) @(negedge clock);

    #1;
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(bus.imem_req_addr), 64'h0);
    chk("rst_cnt", 64'(bus.fb_valid_cnt), 64'd0);
    chk("rst_packets_zero", 64'(bus.fb_packets == '0), 64'd1);

    @(negedge clock);
    reset_n = 1'b1;
    cycle_now(0, 0, '0, 0, 0, 4);
    chk("lit_idle_no_req", 64'(s_reqv), 64'd0);

    g = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    step(1, 0, '0, 0, 0, 4);
    chk("lit_first_req", {31'b0, s_reqv, s_addr}, {31'b0, 1'b1, 32'h0});
    step(0, 1, g, 0, 0, 4);
    chk("lit_wait_cnt0", 64'(s_cnt), 64'd0);
    step(0, 0, '0, 0, 0, 4);
    chk("lit_full_cnt", 64'(s_cnt), 64'd4);
    chk("lit_full_pc3", 64'(s_pc[3]), 64'hC);
    chk("lit_full_inst2", 64'(s_inst[2]), 64'hA2);
    step(0, 0, '0, 1, 32'h18, 4);
    chk("lit_next_req", {31'b0, s_reqv, s_addr}, {31'b0, 1'b1, 32'h10});

    step(1, 0, '0, 0, 0, 4);
    chk("lit_redir_req", 64'(s_addr), 64'h18);
    g = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    step(0, 1, g, 0, 0, 4);
    step(0, 0, '0, 0, 0, 4);
    chk("lit_line_end_cnt", 64'(s_cnt), 64'd2);
    chk("lit_line_end_pcs", {s_pc[1], s_pc[0]}, {32'h1C, 32'h18});
    step(0, 0, '0, 1, 32'h0, 4);
    chk("lit_after_line_req", 64'(s_addr), 64'h20);

    g = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    step(1, 0, '0, 0, 0, 4);
    step(0, 1, g, 0, 0, 4);
    step(0, 0, '0, 0, 0, 1);
    chk("lit_spot1", {s_cnt, s_pc[0]}, {32'b0, 3'd1, 32'h0});
    step(0, 0, '0, 0, 0, 0);
    chk("lit_spot0_stall", {s_cnt, s_reqv}, {60'b0, 3'd0, 1'b0});
    step(0, 0, '0, 0, 0, 3);
    chk("lit_spot3", {s_cnt, s_pc[0]}, {32'b0, 3'd3, 32'h4});
    chk("lit_spot3_pc2", 64'(s_pc[2]), 64'hC);

    step(1, 0, '0, 0, 0, 4);
    chk("lit_drained_req", {31'b0, s_reqv, s_addr}, {31'b0, 1'b1, 32'h10});
    step(0, 0, '0, 1, 32'h100, 4);
    step(0, 0, '0, 0, 0, 4);
    chk("lit_flush_no_req", 64'(s_reqv), 64'd0);
    step(0, 0, '0, 0, 0, 4);
    step(0, 1, {4{32'hDEAD}}, 0, 0, 4);
    chk("lit_stale_cnt0", 64'(s_cnt), 64'd0);
    step(1, 0, '0, 1, 32'h200, 4);
    chk("lit_flush_then_req", {31'b0, s_reqv, s_addr}, {31'b0, 1'b1, 32'h100});
    step(0, 1, {4{32'hBEEF}}, 0, 0, 4);
    chk("lit_flush2_no_req", 64'(s_reqv), 64'd0);
    step(1, 0, '0, 0, 0, 4);
    chk("lit_req_200", 64'(s_addr), 64'h200);
    step(0, 1, {4{32'hF00D}}, 1, 32'h301, 4);
    step(0, 0, '0, 0, 0, 4);
    chk("lit_rsp_redir_req", {31'b0, s_reqv, s_addr}, {31'b0, 1'b1, 32'h300});

    g = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    step(1, 0, '0, 0, 0, 4);
    step(0, 1, g, 0, 0, 4);
    step(0, 0, '0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("async_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("async_rst_cnt", 64'(bus.fb_valid_cnt), 64'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cycle_now(0, 0, '0, 0, 0, 4);
    step(1, 0, '0, 0, 0, 4);
    chk("lit_restart_req", {31'b0, s_reqv, s_addr}, {31'b0, 1'b1, 32'h0});

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rinst = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
        default: rpc = $urandom & 32'hFFF;
      endcase
      step(1'($urandom_range(0, 1)),
           m_out && ($urandom_range(0, 2) == 0),
           rinst,
           $urandom_range(0, 15) == 0,
           rpc,
           3'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
